// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-level main memory behind the cache request port. Accepts one
//            request at a time, applies a fixed latency, then pulses completion.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              send,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wData,
    output logic              done_sender,
    output logic              write_receiver,
    output logic [DATA_W-1:0] memData,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int IDX_W   = ADDR_W - 2;
    localparam int DEPTH   = 1 << IDX_W;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] c_RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] c_WR_LOAD = CNT_W'(WR_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_write;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [DATA_W-1:0] r_mem_data;
    logic [15:0]       r_rd_count;
    logic [15:0]       r_wr_count;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_accept;
    logic w_commit;
    logic w_unused;

    // Byte-lane bits carry no meaning for a word-wide memory.
    assign w_unused = ^addr[1:0];

    assign w_accept = (r_state == S_IDLE) && send;
    assign w_commit = (r_state == S_BUSY) && (r_lat_cnt == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (send) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_lat_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done_sender    = (r_state == S_DONE);
        write_receiver = (r_state == S_DONE) && !r_write;
        busy           = (r_state != S_IDLE);
        memData        = r_mem_data;
        rd_count       = r_rd_count;
        wr_count       = r_wr_count;
    end

    // Request capture, latency countdown and completion bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_lat_cnt  <= '0;
            r_mem_data <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_accept) begin
                r_write   <= write;
                r_idx     <= addr[ADDR_W-1:2];
                r_wdata   <= wData;
                r_lat_cnt <= write ? c_WR_LOAD : c_RD_LOAD;
            end else if ((r_state == S_BUSY) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (w_commit) begin
                if (r_write) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end else begin
                    r_mem_data <= r_mem[r_idx];
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (w_commit && r_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder (vectors, corner sequences,
//            randomized traffic against a word-array reference model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic              clock;
    logic              reset;
    logic              send;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wData;
    logic              done_sender;
    logic              write_receiver;
    logic [DATA_W-1:0] memData;
    logic              busy;
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;

    mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clock(clock), .reset(reset), .send(send), .write(write), .addr(addr),
        .wData(wData), .done_sender(done_sender), .write_receiver(write_receiver),
        .memData(memData), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: a plain word array plus completed-transaction tallies.
    logic [DATA_W-1:0] mdl_mem [1 << (ADDR_W-2)];
    int                mdl_rd = 0;
    int                mdl_wr = 0;
    logic [DATA_W-1:0] last_rd;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete request: drive, drop send after accept, scramble inputs, check completion.
    task automatic txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int k;
        bit got;
        int lat;
        lat = wr ? WR_LAT : RD_LAT;
        @(negedge clock);
        send = 1'b1; write = wr; addr = a; wData = d;
        @(posedge clock);
        #1;
        send = 1'b0; write = 1'($urandom); addr = ADDR_W'($urandom); wData = $urandom;
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clock);
            k++;
            if (done_sender) got = 1'b1;
        end
        chk("latency", k, lat + 1);
        if (got) begin
            chk("write_receiver_at_done", write_receiver, !wr);
            if (wr) begin
                mdl_mem[a >> 2] = d;
                mdl_wr++;
            end else begin
                chk("memData", memData, mdl_mem[a >> 2]);
                last_rd = memData;
                mdl_rd++;
            end
            chk("rd_count", rd_count, 32'(mdl_rd[15:0]));
            chk("wr_count", wr_count, 32'(mdl_wr[15:0]));
        end
        @(negedge clock);
        chk("done_pulse_width", done_sender, 0);
        chk("write_receiver_fall", write_receiver, 0);
        chk("busy_after_done", busy, 0);
        if (!wr) chk("memData_hold", memData, mdl_mem[a >> 2]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int j;
        bit got;
        logic [ADDR_W-1:0] written [$];

        for (int i = 0; i < (1 << (ADDR_W-2)); i++) mdl_mem[i] = '0;
        last_rd = '0;
        send = 1'b0; write = 1'b0; addr = '0; wData = '0;

        vecs[0] = '{1'b1, 10'h040, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 10'h040, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 10'h080, 32'h1,        32'h0};
        vecs[3] = '{1'b1, 10'h084, 32'h2,        32'h0};
        vecs[4] = '{1'b1, 10'h088, 32'h3,        32'h0};
        vecs[5] = '{1'b1, 10'h08C, 32'h4,        32'h0};
        vecs[6] = '{1'b0, 10'h081, 32'h0,        32'h1};
        vecs[7] = '{1'b0, 10'h086, 32'h0,        32'h2};
        vecs[8] = '{1'b0, 10'h08B, 32'h0,        32'h3};
        vecs[9] = '{1'b0, 10'h08C, 32'h0,        32'h4};

        // Reset held three cycles.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_done_sender", done_sender, 0);
        chk("rst_write_receiver", write_receiver, 0);
        chk("rst_memData", memData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count", wr_count, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].wr, vecs[i].a, vecs[i].d);
            if (!vecs[i].wr) chk("vector_read_data", last_rd, vecs[i].exp);
        end

        // Reset in the middle of a write: nothing commits, counters clear.
        txn(1'b1, 10'h0C0, 32'hAAAA5555);
        @(negedge clock);
        send = 1'b1; write = 1'b1; addr = 10'h0C0; wData = 32'h12345678;
        @(posedge clock);
        #1;
        send = 1'b0;
        @(negedge clock);
        chk("busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_busy", busy, 0);
        chk("async_reset_rd_count", rd_count, 0);
        chk("async_reset_wr_count", wr_count, 0);
        mdl_rd = 0; mdl_wr = 0;
        repeat (3) begin
            @(negedge clock);
            chk("no_done_in_reset", done_sender, 0);
        end
        reset = 1'b1;
        txn(1'b0, 10'h0C0, 32'h0);
        chk("dropped_write_old_value", last_rd, 32'hAAAA5555);

        // send held high through DONE: the next request needs an IDLE sample first.
        @(negedge clock);
        send = 1'b1; write = 1'b0; addr = 10'h080;
        @(posedge clock);
        #1;
        addr = 10'h084;
        for (k = 1; k <= RD_LAT + 3; k++) begin
            @(negedge clock);
            if (k == RD_LAT + 1) begin
                chk("held_first_done", done_sender, 1);
                chk("held_first_data", memData, 32'h1);
            end
            if (k == RD_LAT + 2) chk("held_idle_gap", busy, 0);
            if (k == RD_LAT + 3) chk("held_second_accept", busy, 1);
        end
        send = 1'b0;
        j = 1; got = 1'b0;
        while (!got && j < 20) begin
            @(negedge clock);
            j++;
            if (done_sender) got = 1'b1;
        end
        chk("held_second_latency", j, RD_LAT + 1);
        chk("held_second_data", memData, 32'h2);
        mdl_rd += 2;
        chk("held_rd_count", rd_count, 32'(mdl_rd[15:0]));
        @(negedge clock);

        // Write whose inputs are scrambled mid-flight, then read-after-write.
        txn(1'b1, 10'h100, 32'hCAFEF00D);
        txn(1'b0, 10'h100, 32'h0);
        chk("raw_data", last_rd, 32'hCAFEF00D);

        // Randomized traffic; reads only target words written during the run.
        for (int i = 0; i < 150; i++) begin
            if (written.size() == 0 || ($urandom % 2) == 0) begin
                logic [ADDR_W-1:0] a;
                a = ADDR_W'($urandom);
                written.push_back(a);
                txn(1'b1, a, $urandom);
            end else begin
                txn(1'b0, written[$urandom % written.size()], 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
